// File: rtl/key_entry_capture.sv
// Simon game input stage: synchronises and debounces the pushbuttons and round switch,
// builds the toggled guess during a round and hands it off over valid/ready at round close.
module key_entry_capture #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] key_n,
   input  logic       round_go,
   input  logic       entry_ready,
   output logic [3:0] press_pulse,
   output logic [3:0] pattern,
   output logic       entry_valid,
   output logic [3:0] entry_pattern,
   output logic       round_open
);

   // state  | meaning
   // IDLE   | no round; guess held at zero
   // ENTRY  | round open; press pulses toggle guess bits
   // HOLD   | round closed; frozen guess offered until accepted
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ENTRY = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   localparam int                NCH     = 5;
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

   logic [3:0]       key_s1_q, key_s2_q;
   logic             go_s1_q, go_s2_q;

   logic [NCH-1:0]   lvl;
   logic [NCH-1:0]   db_q, db_d;
   logic [NCH-1:0]   db_p1_q, db_p2_q;
   logic [CNT_W-1:0] cnt_q [NCH];
   logic [CNT_W-1:0] cnt_d [NCH];

   logic [3:0]       press_pulse_q, press_pulse_d;
   logic             go_rise_q, go_rise_d;
   logic             go_fall_q, go_fall_d;

   state_t           state_q, state_d;
   logic [3:0]       pattern_q, pattern_d;
   logic             entry_valid_q, entry_valid_d;
   logic [3:0]       entry_pattern_q, entry_pattern_d;
   logic [3:0]       pattern_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         key_s1_q <= 4'hF;
         key_s2_q <= 4'hF;
         go_s1_q  <= 1'b0;
         go_s2_q  <= 1'b0;
      end else begin
         key_s1_q <= key_n;
         key_s2_q <= key_s1_q;
         go_s1_q  <= round_go;
         go_s2_q  <= go_s1_q;
      end
   end

   // Channels 0..3 are the keys as pressed-high levels; channel 4 is the round switch.
   assign lvl = {go_s2_q, ~key_s2_q};

   always_comb begin
      db_d = db_q;
      for (int i = 0; i < NCH; i++) begin
         cnt_d[i] = '0;
         if (lvl[i] != db_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               db_d[i]  = ~db_q[i];
               cnt_d[i] = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         db_q <= '0;
         for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
      end else begin
         db_q <= db_d;
         for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   // Edges are detected on a retimed copy of the debounced state so key pulses
   // and round edges come out of one identical pipeline and stay cycle-aligned.
   always_comb begin
      press_pulse_d = db_p1_q[3:0] & ~db_p2_q[3:0];
      go_rise_d     = db_p1_q[4] & ~db_p2_q[4];
      go_fall_d     = ~db_p1_q[4] & db_p2_q[4];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         db_p1_q       <= '0;
         db_p2_q       <= '0;
         press_pulse_q <= '0;
         go_rise_q     <= 1'b0;
         go_fall_q     <= 1'b0;
      end else begin
         db_p1_q       <= db_q;
         db_p2_q       <= db_p1_q;
         press_pulse_q <= press_pulse_d;
         go_rise_q     <= go_rise_d;
         go_fall_q     <= go_fall_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      pattern_d       = pattern_q;
      entry_valid_d   = entry_valid_q;
      entry_pattern_d = entry_pattern_q;
      pattern_nxt     = pattern_q ^ press_pulse_q;
      case (state_q)
         ST_IDLE: begin
            pattern_d     = '0;
            entry_valid_d = 1'b0;
            if (go_rise_q) state_d = ST_ENTRY;
         end
         ST_ENTRY: begin
            pattern_d = pattern_nxt;
            if (go_fall_q) begin
               entry_pattern_d = pattern_nxt;
               entry_valid_d   = 1'b1;
               state_d         = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (entry_valid_q && entry_ready) begin
               entry_valid_d = 1'b0;
               pattern_d     = '0;
               state_d       = ST_IDLE;
            end
         end
         default: begin
            state_d       = ST_IDLE;
            pattern_d     = '0;
            entry_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         pattern_q       <= '0;
         entry_valid_q   <= 1'b0;
         entry_pattern_q <= '0;
      end else begin
         state_q         <= state_d;
         pattern_q       <= pattern_d;
         entry_valid_q   <= entry_valid_d;
         entry_pattern_q <= entry_pattern_d;
      end
   end

   assign press_pulse   = press_pulse_q;
   assign pattern       = pattern_q;
   assign entry_valid   = entry_valid_q;
   assign entry_pattern = entry_pattern_q;
   assign round_open    = (state_q == ST_ENTRY);

endmodule

// File: tb/tb_key_entry_capture.sv
// Directed bench for key_entry_capture with a short debounce window.
module tb_key_entry_capture;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] key_n;
   logic       round_go;
   logic       entry_ready;
   logic [3:0] press_pulse;
   logic [3:0] pattern;
   logic       entry_valid;
   logic [3:0] entry_pattern;
   logic       round_open;

   int total = 0;
   int bad   = 0;

   key_entry_capture #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
      .clk           (clk),
      .reset         (reset),
      .key_n         (key_n),
      .round_go      (round_go),
      .entry_ready   (entry_ready),
      .press_pulse   (press_pulse),
      .pattern       (pattern),
      .entry_valid   (entry_valid),
      .entry_pattern (entry_pattern),
      .round_open    (round_open)
   );

   always #5 clk = ~clk;

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press_key(input int k);
      @(negedge clk);
      key_n[k] = 1'b0;
      wait_neg(10);
      key_n[k] = 1'b1;
      wait_neg(10);
   endtask

   task automatic test_reset;
      reset = 1'b1; key_n = 4'hF; round_go = 1'b0; entry_ready = 1'b0;
      wait_neg(3);
      total++;
      if ({press_pulse, pattern, entry_valid, entry_pattern, round_open} !== 14'd0) begin
         bad++;
         $display("FAIL reset_outputs got pp=%b pat=%b v=%b ep=%b ro=%b want all 0",
                  press_pulse, pattern, entry_valid, entry_pattern, round_open);
      end
      reset = 1'b0;
      wait_neg(2);
      total++;
      if ({press_pulse, pattern, entry_valid, round_open} !== 10'd0) begin
         bad++;
         $display("FAIL idle_after_reset got pp=%b pat=%b v=%b ro=%b want all 0",
                  press_pulse, pattern, entry_valid, round_open);
      end
   endtask

   task automatic test_press_pulse;
      logic [3:0] exp;
      int pulses;
      @(negedge clk);
      key_n[2] = 1'b0;
      for (int e = 0; e < 10; e++) begin
         @(posedge clk);
         @(negedge clk);
         exp = (e == 7) ? 4'b0100 : 4'b0000;
         total++;
         if (press_pulse !== exp) begin
            bad++;
            $display("FAIL press_latency edge %0d got %b want %b", e, press_pulse, exp);
         end
      end
      key_n[2] = 1'b1;
      pulses = 0;
      for (int e = 0; e < 12; e++) begin
         @(negedge clk);
         if (press_pulse != 4'b0000) pulses++;
      end
      total++;
      if (pulses !== 0) begin
         bad++;
         $display("FAIL release_pulse got %0d pulses want 0", pulses);
      end
      key_n[0] = 1'b0;
      wait_neg(3);
      key_n[0] = 1'b1;
      pulses = 0;
      for (int e = 0; e < 14; e++) begin
         @(negedge clk);
         if (press_pulse != 4'b0000) pulses++;
      end
      total++;
      if (pulses !== 0) begin
         bad++;
         $display("FAIL glitch_pulse got %0d pulses want 0", pulses);
      end
   endtask

   task automatic test_round_entry;
      @(negedge clk);
      round_go = 1'b1;
      wait_neg(10);
      total++;
      if (round_open !== 1'b1 || pattern !== 4'b0000) begin
         bad++;
         $display("FAIL round_open got ro=%b pat=%b want 1 0000", round_open, pattern);
      end
      press_key(1);
      total++;
      if (pattern !== 4'b0010) begin
         bad++;
         $display("FAIL pattern_key1 got %b want 0010", pattern);
      end
      press_key(3);
      total++;
      if (pattern !== 4'b1010) begin
         bad++;
         $display("FAIL pattern_key3 got %b want 1010", pattern);
      end
      press_key(1);
      total++;
      if (pattern !== 4'b1000) begin
         bad++;
         $display("FAIL pattern_key1_again got %b want 1000", pattern);
      end
      round_go = 1'b0;
      wait_neg(10);
      total++;
      if (entry_valid !== 1'b1 || entry_pattern !== 4'b1000 || round_open !== 1'b0) begin
         bad++;
         $display("FAIL round_close got v=%b ep=%b ro=%b want 1 1000 0",
                  entry_valid, entry_pattern, round_open);
      end
   endtask

   task automatic test_hold;
      int unstable;
      int extra;
      unstable = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (entry_valid !== 1'b1 || entry_pattern !== 4'b1000) unstable++;
      end
      total++;
      if (unstable !== 0) begin
         bad++;
         $display("FAIL hold_stable got %0d unstable cycles want 0", unstable);
      end
      press_key(2);
      total++;
      if (pattern !== 4'b1000 || entry_valid !== 1'b1 || entry_pattern !== 4'b1000) begin
         bad++;
         $display("FAIL hold_press got pat=%b v=%b ep=%b want 1000 1 1000",
                  pattern, entry_valid, entry_pattern);
      end
      entry_ready = 1'b1;
      @(negedge clk);
      total++;
      if (entry_valid !== 1'b0 || pattern !== 4'b0000 || round_open !== 1'b0) begin
         bad++;
         $display("FAIL transfer got v=%b pat=%b ro=%b want 0 0000 0",
                  entry_valid, pattern, round_open);
      end
      extra = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (entry_valid) extra++;
      end
      entry_ready = 1'b0;
      total++;
      if (extra !== 0) begin
         bad++;
         $display("FAIL single_transfer got %0d extra valid cycles want 0", extra);
      end
   endtask

   task automatic test_same_cycle;
      @(negedge clk);
      round_go = 1'b1;
      wait_neg(10);
      @(negedge clk);
      key_n[0] = 1'b0;
      round_go = 1'b0;
      wait_neg(10);
      key_n[0] = 1'b1;
      total++;
      if (entry_valid !== 1'b1 || entry_pattern !== 4'b0001) begin
         bad++;
         $display("FAIL same_cycle got v=%b ep=%b want 1 0001", entry_valid, entry_pattern);
      end
      entry_ready = 1'b1;
      wait_neg(2);
      entry_ready = 1'b0;
      wait_neg(10);
      total++;
      if (entry_valid !== 1'b0 || pattern !== 4'b0000) begin
         bad++;
         $display("FAIL same_cycle_drain got v=%b pat=%b want 0 0000", entry_valid, pattern);
      end
   endtask

   task automatic test_reset_mid_round;
      @(negedge clk);
      round_go = 1'b1;
      wait_neg(10);
      press_key(1);
      press_key(2);
      total++;
      if (pattern !== 4'b0110 || round_open !== 1'b1) begin
         bad++;
         $display("FAIL mid_round_pattern got pat=%b ro=%b want 0110 1", pattern, round_open);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      total++;
      if (pattern !== 4'b0000 || entry_valid !== 1'b0 || round_open !== 1'b0) begin
         bad++;
         $display("FAIL async_reset got pat=%b v=%b ro=%b want 0000 0 0",
                  pattern, entry_valid, round_open);
      end
      wait_neg(2);
      reset = 1'b0;
      wait_neg(12);
      total++;
      if (round_open !== 1'b1 || pattern !== 4'b0000) begin
         bad++;
         $display("FAIL new_round got ro=%b pat=%b want 1 0000", round_open, pattern);
      end
      press_key(3);
      round_go = 1'b0;
      wait_neg(10);
      total++;
      if (entry_valid !== 1'b1 || entry_pattern !== 4'b1000) begin
         bad++;
         $display("FAIL new_round_close got v=%b ep=%b want 1 1000", entry_valid, entry_pattern);
      end
      entry_ready = 1'b1;
      wait_neg(2);
      entry_ready = 1'b0;
   endtask

   task automatic test_key_held_reset;
      int pulses;
      int pos;
      @(negedge clk);
      reset = 1'b1;
      key_n[3] = 1'b0;
      wait_neg(3);
      reset = 1'b0;
      pulses = 0;
      pos = -1;
      for (int e = 0; e < 14; e++) begin
         @(posedge clk);
         @(negedge clk);
         if (press_pulse == 4'b1000) begin
            pulses++;
            pos = e;
         end else if (press_pulse != 4'b0000) begin
            pulses = pulses + 100;
         end
      end
      key_n[3] = 1'b1;
      total++;
      if (pulses !== 1 || pos !== 7) begin
         bad++;
         $display("FAIL held_through_reset got %0d pulses at edge %0d want 1 at edge 7", pulses, pos);
      end
      total++;
      if (pattern !== 4'b0000 || round_open !== 1'b0) begin
         bad++;
         $display("FAIL held_idle got pat=%b ro=%b want 0000 0", pattern, round_open);
      end
      wait_neg(12);
   endtask

   initial begin
      test_reset;
      test_press_pulse;
      test_round_entry;
      test_hold;
      test_same_cycle;
      test_reset_mid_round;
      test_key_held_reset;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
